// File: rtl/prbs_pkg.sv
// Shared PRBS31 constants, checker state encoding and the predicted-bit helper.
// Used by the checker, its LFSR core, and the matching generator.
package prbs_pkg;

  localparam int unsigned PRBS_LEN = 31;
  localparam int unsigned TAP_A    = 30;
  localparam int unsigned TAP_B    = 27;
  localparam int unsigned STATE_W  = 2;

  // Encoding 2'd3 is unused; the checker returns it to ST_SEED.
  typedef enum logic [STATE_W-1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  // Next bit of x^31 + x^28 + 1, where s[0] holds the newest bit.
  function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_lfsr_core.sv
// PRBS31 shift register with a predicted-bit output.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-high clear of the register
//   shift_en   shift one bit in at s[0]
//   load_ext   1: shift in ext_bit, 0: shift in the prediction (free-run/flywheel)
//   ext_bit    externally supplied bit
//   pred_c     combinational prediction of the next bit from the current state
//   is_zero_c  combinational flag, register is all zeros
module prbs31_lfsr_core
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic load_ext,
  input  logic ext_bit,
  output logic pred_c,
  output logic is_zero_c
);

  logic [PRBS_LEN-1:0] s;

  // Shift register; newest bit enters at s[0].
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s <= '0;
    end else if (shift_en) begin
      s <= {s[PRBS_LEN-2:0], (load_ext ? ext_bit : pred_c)};
    end
  end

  assign pred_c    = prbs_predict(s);
  assign is_zero_c = (s == '0);

endmodule

// File: rtl/prbs31_checker.sv
// Receive-side PRBS31 checker: self-seeds from the stream, verifies a run of
// correct predictions, then flywheels while locked, counting bit errors and
// dropping lock when too many errors fall inside one window of valid bits.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-high reset
//   din        received serial bit
//   din_valid  din is sampled only when 1; all state holds otherwise
//   clear_cnt  synchronous clear of err_count
//   locked     1 while in ST_LOCKED
//   err_pulse  one-cycle pulse per mismatched valid bit while locked
//   err_count  saturating mismatch count while locked
//   state_dbg  current state encoding
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_BITS   = 64,
  parameter int unsigned WINDOW      = 256,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state_dbg
);

  localparam int unsigned SEED_W = $clog2(PRBS_LEN + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_BITS + 1);
  localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  prbs_state_e        state;
  logic [SEED_W-1:0]  seed_cnt;
  logic [GOOD_W-1:0]  good_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [WIN_W-1:0]   win_err_cnt;

  logic               pred_c;
  logic               is_zero_c;
  logic               shift_en_c;
  logic               load_ext_c;
  logic               bit_err_c;
  logic               lock_err_c;
  logic [WIN_W-1:0]   win_err_nxt_c;

  // Seeding and verifying track the received bits; locked mode flywheels on
  // the prediction so a corrupted bit never poisons later predictions.
  assign shift_en_c    = din_valid && (state == ST_SEED || state == ST_VERIFY ||
                                       state == ST_LOCKED);
  assign load_ext_c    = (state != ST_LOCKED);
  assign bit_err_c     = din ^ pred_c;
  assign lock_err_c    = din_valid && (state == ST_LOCKED) && bit_err_c;
  assign win_err_nxt_c = win_err_cnt + WIN_W'(lock_err_c);

  prbs31_lfsr_core u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en_c),
    .load_ext  (load_ext_c),
    .ext_bit   (din),
    .pred_c    (pred_c),
    .is_zero_c (is_zero_c)
  );

  // Lock FSM with its seed, good-run and loss-of-lock window counters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= ST_SEED;
      seed_cnt    <= '0;
      good_cnt    <= '0;
      win_cnt     <= '0;
      win_err_cnt <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      err_pulse <= lock_err_c;
      case (state)
        ST_SEED: begin
          if (din_valid) begin
            if (seed_cnt == SEED_W'(PRBS_LEN - 1)) begin
              seed_cnt <= '0;
              good_cnt <= '0;
              state    <= ST_VERIFY;
            end else begin
              seed_cnt <= seed_cnt + SEED_W'(1);
            end
          end
        end

        ST_VERIFY: begin
          if (din_valid) begin
            // An all-zero register predicts zeros forever; treat it as a miss.
            if (!bit_err_c && !is_zero_c) begin
              if (good_cnt == GOOD_W'(LOCK_BITS - 1)) begin
                good_cnt    <= '0;
                win_cnt     <= '0;
                win_err_cnt <= '0;
                locked      <= 1'b1;
                state       <= ST_LOCKED;
              end else begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end else begin
              seed_cnt <= '0;
              state    <= ST_SEED;
            end
          end
        end

        ST_LOCKED: begin
          if (din_valid) begin
            // Loss takes priority over window roll-over on the final bit.
            if (win_err_nxt_c == WIN_W'(LOSS_THRESH)) begin
              win_cnt     <= '0;
              win_err_cnt <= '0;
              seed_cnt    <= '0;
              locked      <= 1'b0;
              state       <= ST_SEED;
            end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
              win_cnt     <= '0;
              win_err_cnt <= '0;
            end else begin
              win_cnt     <= win_cnt + WIN_W'(1);
              win_err_cnt <= win_err_nxt_c;
            end
          end
        end

        default: begin
          seed_cnt <= '0;
          locked   <= 1'b0;
          state    <= ST_SEED;
        end
      endcase
    end
  end

  // Saturating error counter; a clear coincident with an error leaves 1.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_count <= '0;
    end else if (clear_cnt) begin
      err_count <= ERR_CNT_W'(lock_err_c);
    end else if (lock_err_c && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
Receive-side checker for the PRBS31 (x^31 + x^28 + 1) serial test stream produced by the project's generator.
- Self-seeds its LFSR from the incoming bits, verifies a run of correct predictions, then declares lock.
- While locked it counts bit errors and drops lock when the error density is too high.
- Sits on the input side of the top level; status drives the dedicated outputs.

Parameters:
LOCK_BITS, 64, consecutive correctly-predicted valid bits needed to declare lock (1..1023)
WINDOW, 256, valid-bit window length for loss-of-lock evaluation (2..65535)
LOSS_THRESH, 8, errors within one window that force loss of lock (1..WINDOW)
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  single clock; all logic rising-edge
rst_n  in  1  synchronous, active-high reset: reset applied on a rising clk edge when rst_n = 1
din  in  1  received serial bit
din_valid  in  1  din sampled only when 1; all counters and the LFSR hold when 0
clear_cnt  in  1  synchronous clear of err_count
locked  out  1  1 while in LOCKED state
err_pulse  out  1  one-cycle pulse for each mismatched valid bit while locked
err_count  out  ERR_CNT_W  saturating count of mismatches while locked
state_dbg  out  2  current state encoding

Behaviour:
- Reset, and the cycle after reset: locked = 0, err_pulse = 0, err_count = 0, state_dbg = SEED (0).
  - LFSR, seed counter, good counter, window counter and window error counter are all cleared.
- LFSR state s[30:0]: s[0] holds the newest bit. Predicted bit p = s[30] ^ s[27]. Each accepted bit shifts in at s[0].
- States: SEED = 0, VERIFY = 1, LOCKED = 2. Encoding 3 is unused and returns to SEED.
- SEED
  - Each valid bit: shift din into s; seed counter +1.
  - After the 31st valid bit, go to VERIFY with good counter = 0.
- VERIFY
  - Each valid bit: shift din into s (the received bit, not p).
  - din == p and s != 0: good counter +1.
  - din != p, or s == 0: go to SEED and clear the seed counter. This rejects an all-zero stream.
  - Good counter reaching LOCK_BITS: go to LOCKED. locked rises on the clock edge that accepts the LOCK_BITS-th good bit.
  - Minimum lock latency from reset release: 31 + LOCK_BITS valid bits.
- LOCKED
  - Each valid bit: shift p into s (flywheel), so a received error never corrupts the prediction.
  - din != p:
    - err_pulse = 1 in the following cycle.
    - err_count increments unless it is at 2^ERR_CNT_W - 1.
    - Window error counter +1.
  - Window counter counts valid bits. When it reaches WINDOW, both window counters clear on the same edge; an error on that final bit counts toward the closing window.
  - Window error counter reaching LOSS_THRESH: go to SEED. locked falls on that edge. err_count is retained. Window counters clear.
- err_pulse: registered; 0 in SEED and VERIFY, and 0 whenever din_valid = 0.
- clear_cnt: err_count is 0 next cycle.
  - If clear_cnt and an error occur in the same cycle, err_count = 1.
  - clear_cnt does not affect state or the window counters.
- rst_n asserted mid-operation overrides everything. On the next edge all outputs are back at reset values.

Decomposition:
- Package prbs_pkg holds:
  - PRBS_LEN = 31, TAP_A = 30, TAP_B = 27 (0-based taps shared with the generator).
  - State enum and its 2-bit encoding.
- One sub-module: prbs31_lfsr_core.
  - 31-bit register with shift-enable, a load-select between external bit and feedback, a predicted-bit output and an is_zero flag.
  - Reused by the generator.

Test Plan:
1. Reset, then clean PRBS31 from seed 0x7FFFFFFF, din_valid = 1 continuously -> locked = 1 exactly after 95 valid bits; err_count = 0 after 10,000 bits.
2. After lock, invert bit 500 -> single err_pulse one cycle later; err_count = 1; locked stays 1; no further errors.
3. After lock, invert 8 bits within one 256-bit window -> locked = 0 on the 8th error, err_count = 8; clean stream continues -> relock after 95 more valid bits.
4. 7 errors per window spread over 10 windows -> locked stays 1, err_count = 70. A constant-zero stream of 1000 bits from reset -> locked never asserts, state_dbg never 2.
5. din_valid asserted 1 cycle in 3, clean stream -> lock after 95 valid bits (about 285 clocks); err_count = 0; outputs hold during invalid cycles.
6. ERR_CNT_W = 4 override:
   - 20 isolated errors -> err_count saturates at 15.
   - clear_cnt coincident with an error -> err_count = 1.
   - rst_n = 1 while locked -> locked = 0, err_count = 0 next edge.
